// File: rtl/rtmq_trg_fifo.sv
// -----------------------------------------------------------------------------
// rtmq_trg_fifo
//
// Trigger-captured FIFO placed directly after a general-purpose register.
// Every delayed side-effect trigger (f_trg) writes the register's data output
// into a circular buffer. A peripheral consumer reads the buffer over a
// first-word-fall-through valid/ready port. Occupancy, full/empty and a sticky
// overflow flag are exposed so firmware can poll back-pressure.
//
// Handshake: a word moves on the m_* port in any cycle where m_valid and
// m_ready are both high at the rising clk edge. m_valid never depends on
// m_ready, and m_data is meaningful only while m_valid is high.
//
// Optional build macro: RTMQ_TRGFIFO_TSP_EN
//   When defined, a free-running W_TSP-bit counter is stored with every
//   pushed word, and m_data becomes {timestamp, reg_in} (timestamp in MSBs).
//
// Parameters:
//   W_REG      data width (width of the upstream GP register)
//   DEPTH_LOG2 log2 of FIFO depth, legal range 1..8
//   W_TSP      timestamp width (only used with RTMQ_TRGFIFO_TSP_EN)
//
// Ports:
//   clk      system clock, posedge
//   rst_n    asynchronous active-low reset
//   reg_in   data output of the upstream GP register
//   f_trg    write trigger; reg_in is valid in the same cycle
//   ovf_clr  single-cycle pulse clearing f_ovf
//   m_data   head-of-FIFO word
//   m_valid  head word available
//   m_ready  consumer accepts the head word
//   cnt      occupancy, 0..2**DEPTH_LOG2
//   f_empty  cnt == 0
//   f_full   cnt == 2**DEPTH_LOG2
//   f_ovf    sticky overflow flag
// -----------------------------------------------------------------------------
module rtmq_trg_fifo #(
  parameter int W_REG      = 32,
  parameter int DEPTH_LOG2 = 4,
  parameter int W_TSP      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [W_REG-1:0]      reg_in,
  input  logic                  f_trg,
  input  logic                  ovf_clr,
`ifdef RTMQ_TRGFIFO_TSP_EN
  output logic [W_TSP+W_REG-1:0] m_data,
`else
  output logic [W_REG-1:0]      m_data,
`endif
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DEPTH_LOG2:0]   cnt,
  output logic                  f_empty,
  output logic                  f_full,
  output logic                  f_ovf
);

  localparam int D = 1 << DEPTH_LOG2;

`ifdef RTMQ_TRGFIFO_TSP_EN
  localparam int W_OUT = W_TSP + W_REG;
`else
  localparam int W_OUT = W_REG;
`endif

  localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2+1)'(D);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  // Elaboration-time parameter sanity checks.
  generate
    if (DEPTH_LOG2 < 1 || DEPTH_LOG2 > 8) begin : g_bad_depth
      $error("rtmq_trg_fifo: DEPTH_LOG2 must be in 1..8");
    end
    if (W_TSP < 1) begin : g_bad_tsp
      $error("rtmq_trg_fifo: W_TSP must be at least 1");
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Storage and pointers
  // ---------------------------------------------------------------------------
  logic [W_OUT-1:0]      mem [D];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [W_OUT-1:0]      w_word;
  logic [DEPTH_LOG2:0]   cnt_nxt;

  logic push;
  logic pop;
  logic ovf_evt;

`ifdef RTMQ_TRGFIFO_TSP_EN
  // Free-running timestamp; wraps naturally at 2**W_TSP.
  logic [W_TSP-1:0] tsp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tsp_q <= '0;
    end else begin
      tsp_q <= tsp_q + W_TSP'(1);
    end
  end

  assign w_word = {tsp_q, reg_in};
`else
  assign w_word = reg_in;
`endif

  // Output is first-word-fall-through: head slot read combinationally.
  assign m_valid = ~f_empty;
  assign m_data  = mem[rd_ptr];

  // A full FIFO still accepts a trigger when the head leaves in the same
  // cycle; the new word lands in the slot being freed.
  assign pop     = m_valid & m_ready;
  assign push    = f_trg & (~f_full | pop);
  assign ovf_evt = f_trg & f_full & ~pop;

  always_comb begin
    cnt_nxt = cnt;
    if (push && !pop) begin
      cnt_nxt = cnt + CNT_ONE;
    end else if (pop && !push) begin
      cnt_nxt = cnt - CNT_ONE;
    end
  end

  // Storage array carries no reset; validity is tracked by cnt alone.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= w_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      f_empty <= 1'b1;
      f_full  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      cnt     <= cnt_nxt;
      f_empty <= (cnt_nxt == '0);
      f_full  <= (cnt_nxt == CNT_FULL);
    end
  end

  // Sticky overflow: a drop in the same cycle as ovf_clr keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_ovf <= 1'b0;
    end else if (ovf_evt) begin
      f_ovf <= 1'b1;
    end else if (ovf_clr) begin
      f_ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rtmq_trg_fifo.sv
// -----------------------------------------------------------------------------
// tb_rtmq_trg_fifo
//
// Directed bench for rtmq_trg_fifo. The driver task applies one cycle of
// inputs, predicts push/pop/overflow from its own occupancy model, and pushes
// the expected word into exp_q when a push is predicted. A monitor on the
// falling edge pops exp_q and compares m_data on every handshake. The driver
// also compares the status outputs after each edge.
// -----------------------------------------------------------------------------
module tb_rtmq_trg_fifo;

  localparam int W_REG      = 32;
  localparam int DEPTH_LOG2 = 4;
  localparam int W_TSP      = 4;
  localparam int D          = 1 << DEPTH_LOG2;

`ifdef RTMQ_TRGFIFO_TSP_EN
  localparam int W_OUT = W_TSP + W_REG;
`else
  localparam int W_OUT = W_REG;
`endif

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic                  clk = 1'b0;
  logic                  rst_n = 1'b1;
  logic [W_REG-1:0]      reg_in = '0;
  logic                  f_trg = 1'b0;
  logic                  ovf_clr = 1'b0;
  logic [W_OUT-1:0]      m_data;
  logic                  m_valid;
  logic                  m_ready = 1'b0;
  logic [DEPTH_LOG2:0]   cnt;
  logic                  f_empty;
  logic                  f_full;
  logic                  f_ovf;

  always #5 clk = ~clk;

  rtmq_trg_fifo #(
    .W_REG      (W_REG),
    .DEPTH_LOG2 (DEPTH_LOG2),
    .W_TSP      (W_TSP)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .reg_in  (reg_in),
    .f_trg   (f_trg),
    .ovf_clr (ovf_clr),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .cnt     (cnt),
    .f_empty (f_empty),
    .f_full  (f_full),
    .f_ovf   (f_ovf)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state and reference model
  // ---------------------------------------------------------------------------
  logic [W_OUT-1:0]    exp_q[$];
  int                  n_pass  = 0;
  int                  n_total = 0;
  logic [DEPTH_LOG2:0] m_cnt   = '0;
  logic                m_ovf   = 1'b0;
  logic [W_TSP-1:0]    m_tsp   = '0;
  logic                last_push;

  function automatic logic [W_OUT-1:0] mk_word(input logic [W_REG-1:0] d);
`ifdef RTMQ_TRGFIFO_TSP_EN
    return {m_tsp, d};
`else
    return d;
`endif
  endfunction

  // Status vector: {cnt, f_full, f_empty, m_valid, f_ovf}
  task automatic check_status(input string name);
    logic [DEPTH_LOG2+4:0] act;
    logic [DEPTH_LOG2+4:0] exp;
    act = {cnt, f_full, f_empty, m_valid, f_ovf};
    exp = {m_cnt, (m_cnt == (DEPTH_LOG2+1)'(D)), (m_cnt == '0), (m_cnt != '0), m_ovf};
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: status {cnt,full,empty,valid,ovf} got %h want %h (t=%0t)",
                  name, act, exp, $time);
  endtask

  task automatic fail_now(input string name);
    n_total++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Driver: one clock cycle of stimulus, then status check after the edge
  // ---------------------------------------------------------------------------
  task automatic drive(input logic trg, input logic [W_REG-1:0] data,
                       input logic rdy, input logic clr, input string name);
    logic p_pop, p_push, p_ovf;
    f_trg   = trg;
    reg_in  = data;
    m_ready = rdy;
    ovf_clr = clr;
    p_pop  = (m_cnt != '0) && rdy;
    p_push = trg && ((m_cnt != (DEPTH_LOG2+1)'(D)) || p_pop);
    p_ovf  = trg && (m_cnt == (DEPTH_LOG2+1)'(D)) && !p_pop;
    if (p_push) exp_q.push_back(mk_word(data));
    last_push = p_push;
    @(posedge clk);
    #1;
    if (p_push && !p_pop) m_cnt = m_cnt + 1'b1;
    else if (p_pop && !p_push) m_cnt = m_cnt - 1'b1;
    if (p_ovf) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    m_tsp = m_tsp + 1'b1;
    check_status(name);
  endtask

  task automatic do_reset(input string name);
    rst_n   = 1'b0;
    f_trg   = 1'b0;
    m_ready = 1'b0;
    ovf_clr = 1'b0;
    reg_in  = '0;
    #1;
    // Reset is asynchronous: outputs must already be cleared before any edge.
    m_cnt = '0;
    m_ovf = 1'b0;
    m_tsp = '0;
    exp_q.delete();
    check_status(name);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    m_tsp = m_tsp + 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: compare m_data on every handshake against the expected queue
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL pop_data: got %h want nothing queued (t=%0t)", m_data, $time);
      end else begin
        logic [W_OUT-1:0] e;
        e = exp_q.pop_front();
        if (m_data === e) n_pass++;
        else $display("FAIL pop_data: got %h want %h (t=%0t)", m_data, e, $time);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int acc;
    int guard;
    #2;
    do_reset("reset_state");

    // Single trigger: word visible the next cycle with m_ready low.
    drive(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, "single_push");
    drive(1'b0, '0, 1'b1, 1'b0, "single_pop");
    // m_ready while empty must be ignored.
    drive(1'b0, '0, 1'b1, 1'b0, "ready_while_empty");

    // Fill to full.
    for (int i = 0; i < D; i++) drive(1'b1, i, 1'b0, 1'b0, "fill");

    // Overflow, clear, then overflow with simultaneous clear (set wins).
    drive(1'b1, 32'h55, 1'b0, 1'b0, "overflow_set");
    drive(1'b0, '0, 1'b0, 1'b1, "overflow_clear");
    drive(1'b1, 32'h55, 1'b0, 1'b1, "overflow_set_wins");
    drive(1'b0, '0, 1'b0, 1'b1, "overflow_clear2");

    // Full with push and pop together: 0xAA takes the freed slot.
    drive(1'b1, 32'hAA, 1'b1, 1'b0, "full_push_pop");
    for (int i = 0; i < D; i++) drive(1'b0, '0, 1'b1, 1'b0, "drain");

    // Empty with trigger and ready: push only.
    drive(1'b1, 32'h77, 1'b1, 1'b0, "empty_push_ready");
    drive(1'b0, '0, 1'b1, 1'b0, "empty_push_ready_pop");

    // Random interleave across several pointer wraps.
    acc = 0;
    guard = 0;
    while (acc < 40 && guard < 400) begin
      drive(1'($urandom_range(0, 1)), 32'h1000 + acc, 1'($urandom_range(0, 1)), 1'b0, "random");
      if (last_push) acc++;
      guard++;
    end
    if (acc < 40) fail_now("random_pushes");
    drive(1'b0, '0, 1'b0, 1'b1, "random_ovf_clear");
    guard = 0;
    while (m_cnt != '0 && guard < 2*D) begin
      drive(1'b0, '0, 1'b1, 1'b0, "random_drain");
      guard++;
    end
    if (m_cnt != '0) fail_now("random_drain");

`ifdef RTMQ_TRGFIFO_TSP_EN
    // Pushes at timestamp 14, 15 and 0 across the counter wrap.
    guard = 0;
    while (m_tsp != 4'hE && guard < 32) begin
      drive(1'b0, '0, 1'b0, 1'b0, "tsp_idle");
      guard++;
    end
    if (m_tsp != 4'hE) fail_now("tsp_align");
    drive(1'b1, 32'hA1, 1'b0, 1'b0, "tsp_push_e");
    drive(1'b1, 32'hA2, 1'b0, 1'b0, "tsp_push_f");
    drive(1'b1, 32'hA3, 1'b0, 1'b0, "tsp_push_0");
    for (int i = 0; i < 3; i++) drive(1'b0, '0, 1'b1, 1'b0, "tsp_drain");
`endif

    // Reset mid-stream with three words stored.
    drive(1'b1, 32'hC1, 1'b0, 1'b0, "pre_reset_push");
    drive(1'b1, 32'hC2, 1'b0, 1'b0, "pre_reset_push");
    drive(1'b1, 32'hC3, 1'b0, 1'b0, "pre_reset_push");
    do_reset("midstream_reset");
    drive(1'b1, 32'h99, 1'b0, 1'b0, "post_reset_push");
    drive(1'b0, '0, 1'b1, 1'b0, "post_reset_pop");
    drive(1'b0, '0, 1'b0, 1'b0, "idle_end");

    n_total++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL queue_empty: got %0d words left want 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
